// File: rtl/fb_pkg.sv
// Shared constants and FSM state type for the mono framebuffer.
// FB_COLUMN_READ_EN adds the column-read state.
package fb_pkg;

  localparam int H_PIXELS_DEFAULT = 128;
  localparam int V_PIXELS_DEFAULT = 64;
  localparam int BYTES_PER_ROW    = H_PIXELS_DEFAULT / 8;
  localparam int MEM_DEPTH        = BYTES_PER_ROW * V_PIXELS_DEFAULT;
  localparam int ADDR_W           = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_WRITE,
    ST_READ_H,
`ifdef FB_COLUMN_READ_EN
    ST_READ_C,
`endif
    ST_DONE
  } fb_state_e;

endpackage

// File: rtl/fb_bram.sv
// Single-port byte RAM, synchronous read, one cycle latency.
// Contents are not reset; the framebuffer clears them itself.
module fb_bram
  import fb_pkg::*;
#(
  parameter int DEPTH = MEM_DEPTH,
  parameter int AW    = ADDR_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // write-first is irrelevant here; read returns old data
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/framebuffer_mono.sv
// 1bpp framebuffer with byte-wide unaligned access and handshakes.
// FB_COLUMN_READ_EN enables 8-pixel vertical (page) reads.
module framebuffer_mono
  import fb_pkg::*;
#(
  parameter int H_PIXELS = H_PIXELS_DEFAULT,
  parameter int V_PIXELS = V_PIXELS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  output logic       rst_complete,
  input  logic       we,
  output logic       w_data_valid,
  input  logic [7:0] w_xpos,
  input  logic [7:0] w_ypos,
  input  logic [7:0] din,
  input  logic       re,
  output logic       r_data_valid,
  output logic [7:0] dout,
  input  logic [7:0] r_xpos,
  input  logic [7:0] r_ypos,
  input  logic       r_mode
);

  localparam int BPR   = H_PIXELS / 8;
  localparam int DEPTH = BPR * V_PIXELS;
  localparam int AW    = $clog2(DEPTH);

  fb_state_e     st;
  logic [3:0]    ph;
  logic [AW-1:0] cnt;
  logic [7:0]    lx, ly, ldin;
  logic [7:0]    l_old, r_old;
  logic          op_wr;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    rdata;

  logic [2:0]    o;
  logic [3:0]    ro;
  logic [4:0]    col_l;
  logic [5:0]    col_r;
  logic          row_ok, l_ok, r_ok;
  logic [AW-1:0] addr_l, addr_r;
  logic [7:0]    new_l, new_r, hread;

  assign o      = lx[2:0];
  assign ro     = 4'd8 - {1'b0, o};
  assign col_l  = lx[7:3];
  assign col_r  = {1'b0, col_l} + 6'd1;
  assign row_ok = int'(ly) < V_PIXELS;
  assign l_ok   = row_ok && (int'(col_l) < BPR);
  assign r_ok   = row_ok && (int'(col_r) < BPR);
  assign addr_l = l_ok ? AW'(int'(ly) * BPR + int'(col_l)) : '0;
  assign addr_r = r_ok ? AW'(int'(ly) * BPR + int'(col_r)) : '0;
  assign new_l  = (l_old & ~(8'hFF >> o)) | (ldin >> o);
  assign new_r  = (r_old & ~(8'hFF << ro)) | (ldin << ro);
  assign hread  = (o == 3'd0) ? l_old : ((l_old << o) | (r_old >> ro));

`ifdef FB_COLUMN_READ_EN
  logic [7:0]    col_sr;
  logic          x_ok, a_ok, c_ok, cbit;
  logic [8:0]    arow, crow;
  logic [AW-1:0] addr_c;

  assign x_ok   = int'(col_l) < BPR;
  assign arow   = {1'b0, ly} + {5'd0, ph};
  assign crow   = arow - 9'd1;
  assign a_ok   = x_ok && (int'(arow) < V_PIXELS);
  assign c_ok   = x_ok && (int'(crow) < V_PIXELS);
  assign addr_c = a_ok ? AW'(int'(arow) * BPR + int'(col_l)) : '0;
  assign cbit   = c_ok && rdata[3'd7 - o];
`else
  logic unused_mode;
  assign unused_mode = r_mode;
`endif

  fb_bram #(.DEPTH(DEPTH), .AW(AW)) u_bram (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (rdata)
  );

  // memory port schedule for each state/phase
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'h00;
    case (st)
      ST_CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = cnt;
      end
      ST_WRITE: begin
        if (ph == 4'd0 || ph == 4'd2) mem_addr = addr_l;
        if (ph == 4'd1 || ph == 4'd3) mem_addr = addr_r;
        if (ph == 4'd2) begin
          mem_we    = l_ok;
          mem_wdata = new_l;
        end
        if (ph == 4'd3) begin
          mem_we    = r_ok && (o != 3'd0);
          mem_wdata = new_r;
        end
      end
      ST_READ_H: begin
        if (ph == 4'd0) mem_addr = addr_l;
        if (ph == 4'd1) mem_addr = addr_r;
      end
`ifdef FB_COLUMN_READ_EN
      ST_READ_C: begin
        if (ph < 4'd8) mem_addr = addr_c;
      end
`endif
      default: ;
    endcase
  end

  // clear sequencer, request acceptance, transfer phases, handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= ST_CLEAR;
      ph           <= 4'd0;
      cnt          <= '0;
      lx           <= 8'h00;
      ly           <= 8'h00;
      ldin         <= 8'h00;
      l_old        <= 8'h00;
      r_old        <= 8'h00;
      op_wr        <= 1'b0;
      rst_complete <= 1'b0;
      w_data_valid <= 1'b0;
      r_data_valid <= 1'b0;
      dout         <= 8'h00;
`ifdef FB_COLUMN_READ_EN
      col_sr       <= 8'h00;
`endif
    end else begin
      unique case (st)
        ST_CLEAR: begin
          if (cnt == AW'(DEPTH - 1)) begin
            st           <= ST_IDLE;
            rst_complete <= 1'b1;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        ST_IDLE: begin
          ph <= 4'd0;
          if (we) begin
            lx    <= w_xpos;
            ly    <= w_ypos;
            ldin  <= din;
            op_wr <= 1'b1;
            st    <= ST_WRITE;
          end else if (re) begin
            lx    <= r_xpos;
            ly    <= r_ypos;
            op_wr <= 1'b0;
`ifdef FB_COLUMN_READ_EN
            st    <= r_mode ? ST_READ_C : ST_READ_H;
`else
            st    <= ST_READ_H;
`endif
          end
        end
        ST_WRITE: begin
          ph <= ph + 4'd1;
          if (ph == 4'd1) l_old <= rdata;
          if (ph == 4'd2) r_old <= rdata;
          if (ph == 4'd4) begin
            st           <= ST_DONE;
            w_data_valid <= 1'b1;
          end
        end
        ST_READ_H: begin
          ph <= ph + 4'd1;
          if (ph == 4'd1) l_old <= l_ok ? rdata : 8'h00;
          if (ph == 4'd2) r_old <= r_ok ? rdata : 8'h00;
          if (ph == 4'd3) begin
            dout         <= hread;
            r_data_valid <= 1'b1;
            st           <= ST_DONE;
          end
        end
`ifdef FB_COLUMN_READ_EN
        ST_READ_C: begin
          ph <= ph + 4'd1;
          if (ph >= 4'd1 && ph <= 4'd8)
            col_sr <= {col_sr[6:0], cbit};
          if (ph == 4'd9) begin
            dout         <= col_sr;
            r_data_valid <= 1'b1;
            st           <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          if (op_wr ? !we : !re) begin
            st           <= ST_IDLE;
            w_data_valid <= 1'b0;
            r_data_valid <= 1'b0;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_mono.sv
// Randomised + directed bench for framebuffer_mono with a pixel-array
// reference model and a queue-based response monitor.
module tb_framebuffer_mono;

  localparam int H = 128;
  localparam int V = 64;
`ifdef FB_COLUMN_READ_EN
  localparam bit COL_EN = 1'b1;
`else
  localparam bit COL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       we = 1'b0;
  logic       re = 1'b0;
  logic       r_mode = 1'b0;
  logic [7:0] w_xpos = 0, w_ypos = 0, din = 0;
  logic [7:0] r_xpos = 0, r_ypos = 0;
  logic       rst_complete, w_data_valid, r_data_valid;
  logic [7:0] dout;

  framebuffer_mono dut (
    .clk          (clk),
    .rst          (rst),
    .rst_complete (rst_complete),
    .we           (we),
    .w_data_valid (w_data_valid),
    .w_xpos       (w_xpos),
    .w_ypos       (w_ypos),
    .din          (din),
    .re           (re),
    .r_data_valid (r_data_valid),
    .dout         (dout),
    .r_xpos       (r_xpos),
    .r_ypos       (r_ypos),
    .r_mode       (r_mode)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int fails  = 0;

  bit pix [V][H];

  typedef struct {
    bit         is_wr;
    logic [7:0] exp;
    int         lat;
    int         issue;
  } item_t;

  item_t q[$];

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic void model_clear();
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        pix[y][x] = 1'b0;
  endfunction

  function automatic void model_write(int x, int y, logic [7:0] d);
    for (int i = 0; i < 8; i++)
      if (x + i < H && y < V) pix[y][x+i] = d[7-i];
  endfunction

  function automatic logic [7:0] model_read(int x, int y, bit m);
    logic [7:0] r;
    bit c;
    int px, py;
    r = 8'h00;
    c = m && COL_EN;
    for (int i = 0; i < 8; i++) begin
      px = c ? x : x + i;
      py = c ? y + i : y;
      if (px < H && py < V) r[7-i] = pix[py][px];
    end
    return r;
  endfunction

  // response monitor
  item_t      it;
  logic       pw = 1'b0;
  logic       pr = 1'b0;
  logic [7:0] held = 8'h00;

  always @(negedge clk) begin
    if (!rst) begin
      if (w_data_valid && !pw) begin
        if (q.size() == 0) check("w_unexpected", 1, 0);
        else begin
          it = q.pop_front();
          check("w_kind", int'(it.is_wr), 1);
          if (it.lat >= 0) check("w_latency", cyc - it.issue - 1, it.lat);
        end
      end
      if (r_data_valid && !pr) begin
        held = dout;
        if (q.size() == 0) check("r_unexpected", 1, 0);
        else begin
          it = q.pop_front();
          check("r_kind", int'(it.is_wr), 0);
          check("r_data", int'(dout), int'(it.exp));
          if (it.lat >= 0) check("r_latency", cyc - it.issue - 1, it.lat);
        end
      end else if (r_data_valid && pr) begin
        check("r_hold", int'(dout), int'(held));
      end
    end
    pw = w_data_valid;
    pr = r_data_valid;
  end

  task automatic wait_valid(bit w, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (w ? w_data_valid : r_data_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check(w ? "w_timeout" : "r_timeout", 0, 1);
  endtask

  task automatic do_write(int x, int y, logic [7:0] d);
    bit ok;
    @(negedge clk);
    w_xpos = 8'(x);
    w_ypos = 8'(y);
    din    = d;
    we     = 1'b1;
    q.push_back('{is_wr: 1'b1, exp: 8'h00, lat: 5, issue: cyc});
    model_write(x, y, d);
    wait_valid(1'b1, ok);
    we = 1'b0;
    @(negedge clk);
    check("w_fall", int'(w_data_valid), 0);
  endtask

  task automatic do_read(int x, int y, bit m, int want, bit timed);
    bit ok;
    logic [7:0] e;
    int lat;
    @(negedge clk);
    e = (want >= 0) ? 8'(want) : model_read(x, y, m);
    lat = timed ? ((m && COL_EN) ? 10 : 4) : -1;
    r_xpos = 8'(x);
    r_ypos = 8'(y);
    r_mode = m;
    re     = 1'b1;
    q.push_back('{is_wr: 1'b0, exp: e, lat: lat, issue: cyc});
    wait_valid(1'b0, ok);
    re = 1'b0;
    @(negedge clk);
    check("r_fall", int'(r_data_valid), 0);
  endtask

  task automatic do_reset(int n);
    int k;
    @(negedge clk);
    rst = 1'b1;
    we  = 1'b0;
    re  = 1'b0;
    repeat (n) @(negedge clk);
    check("rst_complete_rst", int'(rst_complete), 0);
    check("w_valid_rst", int'(w_data_valid), 0);
    check("r_valid_rst", int'(r_data_valid), 0);
    check("dout_rst", int'(dout), 0);
    model_clear();
    q.delete();
    rst = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rst_complete && k < 2000);
    checks++;
    if (k < 1024 || k > 1026) begin
      fails++;
      $display("FAIL clear_time: got %0d cycles, expected 1024..1026", k);
    end
  endtask

  logic [7:0] cc_col [8];
  logic [7:0] row_pat [8];

  initial begin
    bit ok;
    logic [7:0] e;
    int t0;
    row_pat = '{8'hCC, 8'hAA, 8'hF0, 8'h0F, 8'hCC, 8'hAA, 8'hF0, 8'h0F};
    cc_col  = '{8'hEE, 8'hAA, 8'h66, 8'h22, 8'hDD, 8'h99, 8'h55, 8'h11};
    model_clear();

    do_reset(5);
    do_read(0, 0, 1'b0, 8'h00, 1'b1);

    do_write(0, 0, 8'hF0);
    do_write(8, 0, 8'hAA);
    do_write(16, 0, 8'hCC);
    do_write(0, 1, 8'hFF);
    do_write(8, 1, 8'h01);
    do_read(0, 0, 1'b0, 8'hF0, 1'b1);
    do_read(8, 0, 1'b0, 8'hAA, 1'b1);
    do_read(16, 0, 1'b0, 8'hCC, 1'b1);
    do_read(0, 1, 1'b0, 8'hFF, 1'b1);
    do_read(8, 1, 1'b0, 8'h01, 1'b1);

    do_reset(3);
    do_write(4, 0, 8'hF3);
    do_read(0, 0, 1'b0, 8'h0F, 1'b1);
    do_read(8, 0, 1'b0, 8'h30, 1'b1);
    do_read(4, 0, 1'b0, 8'hF3, 1'b1);

    do_write(0, 5, 8'hFF);
    do_write(8, 5, 8'hFF);
    do_write(4, 5, 8'hC3);
    do_read(0, 5, 1'b0, 8'hFC, 1'b1);
    do_read(8, 5, 1'b0, 8'h3F, 1'b1);
    do_read(4, 5, 1'b0, 8'hC3, 1'b1);

    for (int r = 0; r < 8; r++) do_write(0, r, row_pat[r]);
    for (int x = 0; x < 8; x++)
      do_read(x, 0, 1'b1, COL_EN ? int'(cc_col[x]) : -1, 1'b1);
    do_read(3, 3, 1'b1, COL_EN ? 8'h10 : -1, 1'b1);

    do_write(124, 63, 8'hFF);
    do_write(130, 2, 8'hFF);
    do_write(0, 64, 8'hFF);
    do_read(124, 63, 1'b0, 8'hF0, 1'b1);
    do_read(120, 63, 1'b0, -1, 1'b1);
    do_read(130, 2, 1'b0, 8'h00, 1'b1);
    do_read(3, 60, 1'b1, -1, 1'b1);
    do_read(127, 58, 1'b1, -1, 1'b1);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(1, 0) == 1)
        do_write($urandom_range(135, 0), $urandom_range(69, 0),
                 8'($urandom));
      else
        do_read($urandom_range(135, 0), $urandom_range(69, 0),
                1'($urandom_range(1, 0)), -1, 1'b1);
    end

    // simultaneous write and read: write must go first
    @(negedge clk);
    w_xpos = 8'd10;
    w_ypos = 8'd20;
    din    = 8'h5A;
    r_xpos = 8'd8;
    r_ypos = 8'd20;
    r_mode = 1'b0;
    q.push_back('{is_wr: 1'b1, exp: 8'h00, lat: 5, issue: cyc});
    model_write(10, 20, 8'h5A);
    e = model_read(8, 20, 1'b0);
    q.push_back('{is_wr: 1'b0, exp: e, lat: -1, issue: cyc});
    we = 1'b1;
    re = 1'b1;
    wait_valid(1'b1, ok);
    we = 1'b0;
    wait_valid(1'b0, ok);
    re = 1'b0;
    @(negedge clk);
    check("both_fall", int'(r_data_valid | w_data_valid), 0);

    // reset pulse, read issued before clear completes
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    q.delete();
    repeat (2) @(negedge clk);
    r_xpos = 8'd0;
    r_ypos = 8'd0;
    r_mode = 1'b0;
    re = 1'b1;
    t0 = cyc;
    q.push_back('{is_wr: 1'b0, exp: 8'h00, lat: -1, issue: cyc});
    wait_valid(1'b0, ok);
    check("pending_rst_complete", int'(rst_complete), 1);
    checks++;
    if (cyc - t0 < 1000) begin
      fails++;
      $display("FAIL pending_delay: got %0d cycles, expected >= 1000",
               cyc - t0);
    end
    re = 1'b0;
    @(negedge clk);
    check("pending_fall", int'(r_data_valid), 0);

    repeat (5) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
